// File: rtl/washer_pkg.sv
// Shared definitions for the washer controller and plant model: phase encodings,
// default timing constants and a counter-width helper.
package washer_pkg;

    typedef logic [2:0] phase_t;

    localparam phase_t P_IDLE  = 3'd0;
    localparam phase_t P_FILL  = 3'd1;
    localparam phase_t P_DOSE  = 3'd2;
    localparam phase_t P_WASH  = 3'd3;
    localparam phase_t P_DRAIN = 3'd4;
    localparam phase_t P_SPIN  = 3'd5;
    localparam phase_t P_FAULT = 3'd6;

    localparam int DEF_LEVEL_MAX   = 15;
    localparam int DEF_FILL_RATE   = 1;
    localparam int DEF_DRAIN_RATE  = 1;
    localparam int DEF_DOSE_CYCLES = 4;
    localparam int DEF_WASH_CYCLES = 20;
    localparam int DEF_SPIN_CYCLES = 10;

    // A one-bit floor keeps the counter legal for tiny terminal counts.
    function automatic int cnt_width(input int terminal);
        return (terminal > 1) ? $clog2(terminal) : 1;
    endfunction

endpackage

// File: rtl/washer_plant_model_if.sv
// Actuator/sensor bundle between the washer controller (master) and the plant (slave).
interface washer_plant_model_if #(
    parameter int LEVEL_MAX = washer_pkg::DEF_LEVEL_MAX
);
    logic                           door_lock;
    logic                           motor_on;
    logic                           fill_valve_on;
    logic                           drain_valve_on;
    logic                           soap_wash;
    logic                           filled;
    logic                           drained;
    logic                           detergent_added;
    logic                           cycle_timeout;
    logic                           spin_timeout;
    logic [$clog2(LEVEL_MAX+1)-1:0] level;
    logic                           fault;

    modport master (
        output door_lock, motor_on, fill_valve_on, drain_valve_on, soap_wash,
        input  filled, drained, detergent_added, cycle_timeout, spin_timeout, level, fault
    );

    modport slave (
        input  door_lock, motor_on, fill_valve_on, drain_valve_on, soap_wash,
        output filled, drained, detergent_added, cycle_timeout, spin_timeout, level, fault
    );
endinterface

// File: rtl/plant_timer.sv
// Saturating up-counter with enable, synchronous clear and a held terminal flag.
module plant_timer
    import washer_pkg::*;
#(
    parameter  int TERMINAL = 4,
    localparam int CW       = cnt_width(TERMINAL)
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic done
);
    localparam logic [CW-1:0] LAST = CW'(TERMINAL - 1);

    logic [CW-1:0] cnt;

    // The flag rises on the enabled cycle that finds the count already at its last value,
    // so done appears after exactly TERMINAL enabled cycles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt  <= '0;
            done <= 1'b0;
        end else if (clr) begin
            cnt  <= '0;
            done <= 1'b0;
        end else if (en) begin
            if (cnt == LAST) begin
                done <= 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/washer_plant_model.sv
// Closed-loop washer plant: tank level, detergent dosing, wash and spin timers,
// plus a sticky fault on illegal actuator combinations.
module washer_plant_model
    import washer_pkg::*;
#(
    parameter int LEVEL_MAX   = DEF_LEVEL_MAX,
    parameter int FILL_RATE   = DEF_FILL_RATE,
    parameter int DRAIN_RATE  = DEF_DRAIN_RATE,
    parameter int DOSE_CYCLES = DEF_DOSE_CYCLES,
    parameter int WASH_CYCLES = DEF_WASH_CYCLES,
    parameter int SPIN_CYCLES = DEF_SPIN_CYCLES
) (
    input logic                  clk,
    input logic                  reset,
    washer_plant_model_if.slave  bus
);
    localparam int LW = $clog2(LEVEL_MAX + 1);

    localparam logic [LW-1:0] LVL_FULL   = LW'(LEVEL_MAX);
    localparam logic [LW-1:0] FILL_LIMIT = LW'(LEVEL_MAX - FILL_RATE);
    localparam logic [LW-1:0] FILL_STEP  = LW'(FILL_RATE);
    localparam logic [LW-1:0] DRAIN_STEP = LW'(DRAIN_RATE);

    logic [LW-1:0] level_q;
    phase_t        phase_q;
    phase_t        phase_d;
    logic          filled_w;
    logic          drained_w;
    logic          frozen;
    logic          dose_done;
    logic          wash_done;
    logic          spin_done;

    assign filled_w  = (level_q == LVL_FULL);
    assign drained_w = (level_q == '0);

    // Phase decision for this edge; every action below keys off phase_d so a
    // command takes effect on the same edge that samples it.
    always_comb begin
        phase_d = P_IDLE;
        if (phase_q == P_FAULT
            || (bus.fill_valve_on && bus.drain_valve_on)
            || (!bus.door_lock && (bus.motor_on || bus.fill_valve_on || bus.drain_valve_on))) begin
            phase_d = P_FAULT;
        end else if (bus.fill_valve_on) begin
            phase_d = P_FILL;
        end else if (bus.drain_valve_on && !drained_w) begin
            phase_d = P_DRAIN;
        end else if (bus.drain_valve_on) begin
            phase_d = P_SPIN;
        end else if (bus.motor_on) begin
            phase_d = P_WASH;
        end else if (bus.door_lock && bus.soap_wash && filled_w && !dose_done) begin
            phase_d = P_DOSE;
        end
    end

    assign frozen = (phase_d == P_FAULT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase_q <= P_IDLE;
            level_q <= '0;
        end else begin
            phase_q <= phase_d;
            case (phase_d)
                P_FILL:  level_q <= (level_q > FILL_LIMIT) ? LVL_FULL : level_q + FILL_STEP;
                P_DRAIN: level_q <= (level_q < DRAIN_STEP) ? '0 : level_q - DRAIN_STEP;
                default: level_q <= level_q;
            endcase
        end
    end

    plant_timer #(.TERMINAL(DOSE_CYCLES)) u_dose (
        .clk   (clk),
        .reset (reset),
        .en    (phase_d == P_DOSE),
        .clr   (!frozen && !bus.door_lock),
        .done  (dose_done)
    );

    plant_timer #(.TERMINAL(WASH_CYCLES)) u_wash (
        .clk   (clk),
        .reset (reset),
        .en    (phase_d == P_WASH),
        .clr   (!frozen && !bus.motor_on),
        .done  (wash_done)
    );

    plant_timer #(.TERMINAL(SPIN_CYCLES)) u_spin (
        .clk   (clk),
        .reset (reset),
        .en    (phase_d == P_SPIN),
        .clr   (!frozen && !bus.drain_valve_on),
        .done  (spin_done)
    );

    assign bus.filled          = filled_w;
    assign bus.drained         = drained_w;
    assign bus.detergent_added = dose_done;
    assign bus.cycle_timeout   = wash_done;
    assign bus.spin_timeout    = spin_done;
    assign bus.level           = level_q;
    assign bus.fault           = (phase_q == P_FAULT);

endmodule

// File: tb/tb_washer_plant_model.sv
// Directed scoreboard bench for washer_plant_model: expected output vectors are queued
// as each command is driven and compared once the DUT has sampled it.
module tb_washer_plant_model;

    localparam logic [4:0] C_NONE  = 5'b00000;
    localparam logic [4:0] C_LOCK  = 5'b10000;
    localparam logic [4:0] C_MOTOR = 5'b01000;
    localparam logic [4:0] C_FILL  = 5'b00100;
    localparam logic [4:0] C_DRAIN = 5'b00010;
    localparam logic [4:0] C_SOAP  = 5'b00001;

    typedef struct {
        logic [9:0] v;
        string      tag;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    exp_t sb_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    washer_plant_model_if #(.LEVEL_MAX(15)) bus ();

    washer_plant_model #(
        .LEVEL_MAX   (15),
        .FILL_RATE   (1),
        .DRAIN_RATE  (1),
        .DOSE_CYCLES (4),
        .WASH_CYCLES (20),
        .SPIN_CYCLES (10)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Packed as {fault, spin_timeout, cycle_timeout, detergent_added, drained, filled, level}.
    function automatic logic [9:0] e(input int lvl, input bit fi, input bit dr, input bit det,
                                     input bit ct, input bit st, input bit ft);
        logic [3:0] l;
        l = 4'(lvl);
        return {ft, st, ct, det, dr, fi, l};
    endfunction

    function automatic logic [9:0] observed();
        return {bus.fault, bus.spin_timeout, bus.cycle_timeout, bus.detergent_added,
                bus.drained, bus.filled, bus.level};
    endfunction

    task automatic drive(input logic [4:0] cmd);
        bus.door_lock      = cmd[4];
        bus.motor_on       = cmd[3];
        bus.fill_valve_on  = cmd[2];
        bus.drain_valve_on = cmd[1];
        bus.soap_wash      = cmd[0];
    endtask

    task automatic push_exp(input logic [9:0] v, input string tag);
        exp_t x;
        x.v   = v;
        x.tag = tag;
        sb_q.push_back(x);
    endtask

    task automatic check_output();
        exp_t       x;
        logic [9:0] obs;
        vectors++;
        if (sb_q.size() == 0) begin
            miscompares++;
            $display("[TB] FAIL scoreboard_empty: observed %h expected a queued vector", observed());
        end else begin
            x   = sb_q.pop_front();
            obs = observed();
            assert (obs === x.v) else begin
                miscompares++;
                $error("[TB] FAIL %s: observed %h expected %h", x.tag, obs, x.v);
            end
        end
    endtask

    task automatic check_counter(input logic [4:0] actual, input logic [4:0] expected,
                                 input string tag);
        vectors++;
        assert (actual === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, actual, expected);
        end
    endtask

    // Called at a falling edge: drive, queue the expectation, let one rising edge sample it.
    task automatic apply_stimulus(input logic [4:0] cmd, input logic [9:0] exp_v,
                                  input string tag);
        drive(cmd);
        push_exp(exp_v, tag);
        @(posedge clk);
        #1;
        check_output();
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b0;
        drive(C_NONE);
        @(negedge clk);
        push_exp(e(0, 0, 1, 0, 0, 0, 0), "reset_state");
        check_output();
        reset = 1'b1;

        for (int i = 0; i < 10; i++)
            apply_stimulus(C_NONE, e(0, 0, 1, 0, 0, 0, 0), "idle");

        for (int i = 1; i <= 15; i++)
            apply_stimulus(C_LOCK | C_FILL, e(i, i == 15, 0, 0, 0, 0, 0), "fill");
        apply_stimulus(C_LOCK | C_FILL, e(15, 1, 0, 0, 0, 0, 0), "fill_saturate");

        for (int i = 1; i <= 5; i++)
            apply_stimulus(C_LOCK | C_SOAP, e(15, 1, 0, i >= 4, 0, 0, 0), "dose");

        for (int i = 1; i <= 25; i++)
            apply_stimulus(C_LOCK | C_SOAP | C_MOTOR, e(15, 1, 0, 1, i >= 20, 0, 0), "wash");
        apply_stimulus(C_LOCK | C_SOAP, e(15, 1, 0, 1, 0, 0, 0), "wash_release");

        for (int i = 1; i <= 15; i++)
            apply_stimulus(C_LOCK | C_SOAP | C_DRAIN, e(15 - i, 0, i == 15, 1, 0, 0, 0), "drain");
        for (int j = 1; j <= 11; j++)
            apply_stimulus(C_LOCK | C_SOAP | C_DRAIN, e(0, 0, 1, 1, 0, j >= 10, 0), "spin");
        apply_stimulus(C_LOCK | C_SOAP, e(0, 0, 1, 1, 0, 0, 0), "spin_release");
        apply_stimulus(C_NONE, e(0, 0, 1, 0, 0, 0, 0), "unlock_clears_dose");

        for (int i = 1; i <= 7; i++)
            apply_stimulus(C_LOCK | C_FILL, e(i, 0, 0, 0, 0, 0, 0), "refill");
        apply_stimulus(C_LOCK | C_FILL | C_DRAIN, e(7, 0, 0, 0, 0, 0, 1), "fault_entry");
        apply_stimulus(C_LOCK, e(7, 0, 0, 0, 0, 0, 1), "fault_sticky");
        apply_stimulus(C_NONE, e(7, 0, 0, 0, 0, 0, 1), "fault_sticky_unlocked");
        apply_stimulus(C_LOCK | C_FILL, e(7, 0, 0, 0, 0, 0, 1), "fault_frozen");

        reset = 1'b0;
        drive(C_NONE);
        #1;
        push_exp(e(0, 0, 1, 0, 0, 0, 0), "fault_reset");
        check_output();
        @(negedge clk);
        reset = 1'b1;

        apply_stimulus(C_MOTOR, e(0, 0, 1, 0, 0, 0, 1), "unlocked_motor_fault");
        reset = 1'b0;
        drive(C_NONE);
        #1;
        push_exp(e(0, 0, 1, 0, 0, 0, 0), "unlocked_reset");
        check_output();
        @(negedge clk);
        reset = 1'b1;

        for (int i = 1; i <= 5; i++)
            apply_stimulus(C_LOCK | C_MOTOR, e(0, 0, 1, 0, 0, 0, 0), "wash_partial");
        for (int i = 1; i <= 9; i++)
            apply_stimulus(C_LOCK | C_MOTOR | C_FILL, e(i, 0, 0, 0, 0, 0, 0), "fill_over_wash");
        check_counter(5'(dut.u_wash.cnt), 5'd5, "wash_held");

        #2;
        reset = 1'b0;
        #1;
        push_exp(e(0, 0, 1, 0, 0, 0, 0), "async_reset");
        check_output();
        check_counter(5'(dut.u_wash.cnt), 5'd0, "wash_cleared");
        @(negedge clk);
        reset = 1'b1;

        for (int i = 1; i <= 20; i++)
            apply_stimulus(C_LOCK | C_MOTOR, e(0, 0, 1, 0, i >= 20, 0, 0), "wash_restart");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/washer_plant_model.md
Name: washer_plant_model

Overview:
- Responder side of the washer actuator/sensor interface.
- Consumes the controller's actuator commands: motor, fill valve, drain valve, door lock and phase flags.
- Produces the sensor and timeout signals the controller waits on: filled, drained, detergent_added, cycle_timeout, spin_timeout.
- Models tank level, detergent dosing, wash timer and spin timer. Used as the closed-loop plant in simulation and as a bring-up stand-in on FPGA.

Parameters:
- LEVEL_MAX, 15, full-tank level in level units; filled when level equals LEVEL_MAX.
- FILL_RATE, 1, level units added per cycle while filling; must be ≥1 and ≤LEVEL_MAX.
- DRAIN_RATE, 1, level units removed per cycle while draining; must be ≥1 and ≤LEVEL_MAX.
- DOSE_CYCLES, 4, cycles of dosing before detergent_added.
- WASH_CYCLES, 20, motor-on cycles before cycle_timeout.
- SPIN_CYCLES, 10, spin cycles before spin_timeout.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- door_lock  in  1  door locked command
- motor_on  in  1  wash motor command
- fill_valve_on  in  1  fill valve command
- drain_valve_on  in  1  drain valve command
- soap_wash  in  1  controller is in, or past, the soap phase
- filled  out  1  level == LEVEL_MAX
- drained  out  1  level == 0
- detergent_added  out  1  dose complete; held high
- cycle_timeout  out  1  wash time elapsed; held high
- spin_timeout  out  1  spin time elapsed; held high
- level  out  $clog2(LEVEL_MAX+1)  current tank level
- fault  out  1  sticky illegal-command flag

Behaviour:
- Reset: while reset=0, all state clears asynchronously.
  - level=0, so drained=1.
  - filled, detergent_added, cycle_timeout, spin_timeout and fault are 0; all counters are 0.
  - Reset mid-operation discards level and timers immediately.
- All outputs decode registered state only; there is no combinational path from any input to any output. Command effects are visible one cycle after they are sampled.
- Plant phase register (enum), re-evaluated every clk edge with priority top to bottom:
  - P_FAULT: sticky until reset; all actions frozen. Entered when a command is illegal:
    - fill_valve_on and drain_valve_on both high, or
    - motor_on, fill_valve_on or drain_valve_on high while door_lock=0.
  - P_FILL: fill_valve_on=1. Level increments by FILL_RATE, saturating at LEVEL_MAX.
  - P_DRAIN: drain_valve_on=1 and level>0. Level decrements by DRAIN_RATE, saturating at 0.
  - P_SPIN: drain_valve_on=1 and level==0. spin_cnt increments; spin_timeout sets when spin_cnt reaches SPIN_CYCLES-1 and holds.
  - P_WASH: motor_on=1. wash_cnt increments; cycle_timeout sets when wash_cnt reaches WASH_CYCLES-1 and holds.
  - P_DOSE: door_lock=1, soap_wash=1, filled=1, all actuators off, detergent_added=0. dose_cnt increments; detergent_added sets when dose_cnt reaches DOSE_CYCLES-1.
  - P_IDLE: none of the above.
- Timer clearing:
  - wash_cnt and cycle_timeout clear on the first cycle motor_on=0.
  - spin_cnt and spin_timeout clear on the first cycle drain_valve_on=0.
  - dose_cnt holds when not in P_DOSE; it and detergent_added clear when door_lock falls.
- Saturation: a fill step that would overshoot clamps level to LEVEL_MAX; a drain step that would undershoot clamps it to 0. Level never wraps.
- Counter widths are $clog2 of the respective parameter. Counters saturate at terminal-1 and never wrap.
- Both filled and drained can never be high together (LEVEL_MAX≥1).
- A drain that empties the tank passes to P_SPIN on the following cycle without drain_valve_on toggling; spin time counts from the first cycle with level==0.
- motor_on with drain_valve_on: drain/spin takes priority; wash_cnt holds.

Decomposition:
- Shared package washer_pkg: phase enum (P_IDLE, P_FILL, P_DOSE, P_WASH, P_DRAIN, P_SPIN, P_FAULT) and default timing constants. Reuse the controller's state encodings if the controller migrates to the package.
- One natural sub-module: plant_timer, a saturating up-counter with enable, synchronous clear and a held terminal flag. Instantiated three times: dose, wash, spin.

Test Plan:
- Reset release, no commands -> drained=1, level=0, all other outputs 0 for 10 cycles.
- Lock, fill_valve_on held, defaults -> level counts 1..15; filled=1 on the 15th cycle after the first sampled command. Then all actuators off with soap_wash=1 -> detergent_added=1 after 4 cycles.
- motor_on held 25 cycles -> cycle_timeout rises after 20 cycles and stays high; motor_on low -> cycle_timeout=0 next cycle.
- From level 15, drain_valve_on held -> drained=1 after 15 cycles; spin_timeout high 10 cycles later. Releasing drain clears it.
- fill_valve_on and drain_valve_on both high at level 7 -> fault=1 next cycle; level stays 7; fault persists after commands drop, until reset.
- Reset asserted at level 9 during a fill with wash_cnt mid-count -> level=0, drained=1 and counters 0 immediately, without waiting for clk.
